rf_dump: RTL and testbench
==========================

Name: rf_dump

Overview:
- Debug readout engine on the read side of the register file.
- On a start pulse it walks every register address in turn, samples the read-port data and serialises each word on a single UART-style line (start bit, data LSB first, stop bit).
- It sits beside the core. It drives one spare register-file read-address port and brings out one tx pin for lab and bench inspection of architectural state.

Parameters:
- DW, 8, register data width in bits.
- RFW, 2, register address width; 2**RFW registers are dumped.
- CPB, 4, clocks per serial bit; legal range >= 1. Elaboration fails below 1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled on posedge.
- rd_address  output  RFW  register-file read address, registered.
- rd_data  input  DW  combinational read data from the register file for rd_address.
- tx  output  1  serial line, registered; idle high.
- busy  output  1  high from the cycle after start is accepted until the done cycle.
- done  output  1  one-cycle pulse after the final stop bit.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values (immediate on rst_n low, independent of clk):
  - tx=1, busy=0, done=0, rd_address=0.
  - State IDLE; all counters 0.
- States: IDLE, ADDR, START, DATA, STOP.
- IDLE:
  - tx=1.
  - start=1 at a posedge: busy<=1, rd_address<=0, state<=ADDR.
  - start while busy is ignored; no queuing.
- ADDR (exactly 1 cycle): rd_address is held stable for the whole cycle. The register file writes on the falling edge, so the word captured reflects all writes up to and including the mid-cycle negedge. The capture is as follows:
  - At the posedge ending ADDR: shift register <= rd_data, tx<=0, baud counter cleared, state<=START.
- START: tx=0 for CPB cycles, then tx<=shift[0], bit counter<=0, state<=DATA.
- DATA: each bit is held CPB cycles, then the next bit follows:
  - Shift right after each bit.
  - After bit DW-1: tx<=1, state<=STOP.
- STOP: tx=1 for CPB cycles, then:
  - If rd_address != 2**RFW-1: rd_address<=rd_address+1, state<=ADDR.
  - Else: done<=1 for one cycle, busy<=0, rd_address<=0, state<=IDLE.
- Timing:
  - Per word: 1 + (DW+2)*CPB cycles.
  - Total busy time: 2**RFW * (1 + (DW+2)*CPB) cycles.
  - done is asserted in the first cycle busy is 0.
- Counters and width:
  - Baud counter width is clog2(CPB) with a minimum of 1; it wraps at CPB-1.
  - Bit counter width is clog2(DW) with a minimum of 1.
  - rd_address increments without wrap inside a dump; the last address ends the dump.
- Register 0 is dumped like any other and reads zero on a correct register file.
- rd_data changes outside the ADDR capture edge have no effect on the frame in flight.
- start in the same cycle as done: ignored, because the block is still leaving STOP; a new dump needs start while busy=0 and done=0 or later.
- Reset mid-dump:
  - tx goes high immediately and the frame is abandoned.
  - No done pulse.
  - The next start restarts at address 0.
- tx never glitches: it is driven only from a flop.

Test Plan:
- Reset idle: hold rst_n=0 then release, no start for 50 cycles -> tx=1, busy=0, done=0, rd_address=0 throughout.
- Full dump, DW=8 RFW=2 CPB=4, registers {00,FF,A5,3C}, pulse start -> four frames decode to 0x00,0xFF,0xA5,0x3C in order; busy high exactly 164 cycles; single done pulse the cycle after busy falls.
- Bit timing: same setup as the full dump, word 0xA5 -> after start bit, tx reads 1,0,1,0,0,1,0,1, each held exactly 4 cycles; stop bit high 4 cycles; rd_address=2 during that frame's ADDR cycle.
- Write during dump: negedge write of 0x77 to register 3 while register 1 is transmitting -> frame 3 carries 0x77. A write to register 1 mid-frame does not alter frame 1.
- Start ignored while busy: extra start pulses during frame 2 -> still exactly 4 frames, one done, 164 busy cycles.
- Reset mid-operation: assert rst_n low during the DATA state of frame 1, then release and pulse start -> tx high asynchronously, no done, new dump begins at address 0 and completes normally.

Source files
------------

// File: rtl/rf_dump_if.sv
// Bundle between the register-file dump engine and its environment: the spare
// read port of the register file, the start/busy/done control and the serial tx line.
interface rf_dump_if #(
    parameter int DW  = 8,
    parameter int RFW = 2
);
    logic           start;
    logic [RFW-1:0] rd_address;
    logic [DW-1:0]  rd_data;
    logic           tx;
    logic           busy;
    logic           done;

    // The dump engine owns the read address and the serial line.
    modport master (
        input  start,
        input  rd_data,
        output rd_address,
        output tx,
        output busy,
        output done
    );

    modport slave (
        output start,
        output rd_data,
        input  rd_address,
        input  tx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/rf_dump.sv
// Register-file dump engine: walks every register address on start and sends
// each word as a UART-style frame (start bit, DW data bits LSB first, stop bit).
module rf_dump #(
    parameter int DW  = 8,
    parameter int RFW = 2,
    parameter int CPB = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    rf_dump_if.master bus
);

    localparam int BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BIT_W  = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DW - 1);
    localparam logic [RFW-1:0]    ADDR_LAST = '1;

    generate
        if (CPB < 1) begin : g_bad_cpb
            $error("rf_dump: CPB must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     shift_q, shift_d;
    logic [BAUD_W-1:0] baud_q,  baud_d;
    logic [BIT_W-1:0]  bit_q,   bit_d;
    logic [RFW-1:0]    addr_q,  addr_d;
    logic              tx_q,    tx_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              baud_wrap;

    assign baud_wrap = (baud_q == BAUD_LAST);

    always_comb begin
        // NOTE: every next-state signal gets a default before the case so no path
        // through the case leaves one unassigned, which would infer a latch.
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        addr_d  = addr_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                // A start coinciding with the done pulse is still leaving the dump.
                if (bus.start && !done_q) begin
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                shift_d = bus.rd_data;
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = S_START;
            end

            S_START: begin
                if (baud_wrap) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (addr_q != ADDR_LAST) begin
                        addr_d  = addr_q + RFW'(1);
                        state_d = S_ADDR;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        addr_d  = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            addr_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            addr_q  <= addr_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.rd_address = addr_q;
    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_rf_dump.sv
// Directed bench for rf_dump: records tx/busy/done/rd_address once per cycle on
// the falling edge and compares them against the frame timing of a 4 x 8-bit dump.
module tb_rf_dump;

    localparam int DW       = 8;
    localparam int RFW      = 2;
    localparam int CPB      = 4;
    localparam int NWORDS   = 4;
    localparam int WORD_CYC = 1 + (DW + 2) * CPB;   // 41
    localparam int BUSY_CYC = NWORDS * WORD_CYC;    // 164
    localparam int TR_MAX   = 256;

    typedef enum int { EV_START, EV_WRITE, EV_RST_ON, EV_RST_OFF } ev_kind_e;
    typedef struct {
        int       cyc;
        ev_kind_e kind;
        int       addr;
        int       val;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rf_dump_if #(.DW(DW), .RFW(RFW)) bus ();

    rf_dump #(.DW(DW), .RFW(RFW), .CPB(CPB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Register-file model: written on the falling edge, read combinationally.
    logic [DW-1:0] regs [NWORDS];
    assign bus.rd_data = regs[bus.rd_address];

    logic           tr_tx   [TR_MAX];
    logic           tr_busy [TR_MAX];
    logic           tr_done [TR_MAX];
    logic [RFW-1:0] tr_addr [TR_MAX];
    ev_t            evq [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic add_ev(input int cyc, input ev_kind_e kind, input int addr, input int val);
        ev_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.addr = addr;
        e.val  = val;
        evq.push_back(e);
    endtask

    task automatic load_regs(input logic [DW-1:0] w [NWORDS]);
        for (int i = 0; i < NWORDS; i++) regs[i] = w[i];
    endtask

    // Sample index k is the falling edge in the middle of cycle k; events for
    // index k are applied right after that sample.
    task automatic record(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tr_tx[k]   = bus.tx;
            tr_busy[k] = bus.busy;
            tr_done[k] = bus.done;
            tr_addr[k] = bus.rd_address;
            bus.start  = 1'b0;
            foreach (evq[i]) begin
                if (evq[i].cyc == k) begin
                    case (evq[i].kind)
                        EV_START:   bus.start = 1'b1;
                        EV_WRITE:   regs[evq[i].addr] = evq[i].val[DW-1:0];
                        EV_RST_ON: begin
                            rst_n = 1'b0;
                            #1;
                            check("async reset tx",   32'(bus.tx),         32'd1);
                            check("async reset busy", 32'(bus.busy),       32'd0);
                            check("async reset done", 32'(bus.done),       32'd0);
                            check("async reset addr", 32'(bus.rd_address), 32'd0);
                        end
                        EV_RST_OFF: rst_n = 1'b1;
                        default: ;
                    endcase
                end
            end
        end
        evq.delete();
    endtask

    // Ideal tx level for sample k of a dump started at sample 0.
    function automatic logic exp_tx(input int k, input logic [DW-1:0] w [NWORDS]);
        int wi, off;
        if (k < 1 || k > BUSY_CYC) return 1'b1;
        wi  = (k - 1) / WORD_CYC;
        off = (k - 1) % WORD_CYC;
        if (off == 0) return 1'b1;
        if (off <= CPB) return 1'b0;
        if (off <= CPB + DW * CPB) return w[wi][(off - 1 - CPB) / CPB];
        return 1'b1;
    endfunction

    task automatic check_dump(input string pfx, input logic [DW-1:0] w [NWORDS], input int n);
        int wave_err, addr_err, busy_cnt, done_cnt, done_at;
        logic [DW-1:0] dec;
        for (int wi = 0; wi < NWORDS; wi++) begin
            for (int b = 0; b < DW; b++)
                dec[b] = tr_tx[1 + wi * WORD_CYC + 1 + CPB + b * CPB + CPB / 2];
            check($sformatf("%s frame%0d data", pfx, wi), 32'(dec), 32'(w[wi]));
        end
        wave_err = 0; addr_err = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int k = 0; k < n; k++) begin
            if (tr_tx[k] !== exp_tx(k, w)) wave_err++;
            if (tr_addr[k] !== ((k >= 1 && k <= BUSY_CYC) ? RFW'((k - 1) / WORD_CYC) : RFW'(0)))
                addr_err++;
            if (tr_busy[k] === 1'b1) busy_cnt++;
            if (tr_done[k] === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        check({pfx, " tx waveform errors"},   32'(wave_err), 32'd0);
        check({pfx, " rd_address errors"},    32'(addr_err), 32'd0);
        check({pfx, " busy cycles"},          32'(busy_cnt), 32'(BUSY_CYC));
        check({pfx, " done pulses"},          32'(done_cnt), 32'd1);
        check({pfx, " done cycle"},           32'(done_at),  32'(BUSY_CYC + 1));
        check({pfx, " busy low at done"},     32'(tr_busy[BUSY_CYC + 1]), 32'd0);
        check({pfx, " busy high last cycle"}, 32'(tr_busy[BUSY_CYC]),     32'd1);
    endtask

    logic [DW-1:0] base_w  [NWORDS] = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    logic [DW-1:0] wr_w    [NWORDS] = '{8'h00, 8'hFF, 8'hA5, 8'h77};
    logic [DW-1:0] rst_w   [NWORDS] = '{8'h00, 8'h5A, 8'hA5, 8'h3C};

    initial begin
        int err_tx, err_busy, err_done, err_addr, cnt;
        bus.start = 1'b0;
        load_regs(base_w);

        // Reset values while held, then 50 idle cycles with no start.
        repeat (3) @(negedge clk);
        check("reset tx",   32'(bus.tx),         32'd1);
        check("reset busy", 32'(bus.busy),       32'd0);
        check("reset done", 32'(bus.done),       32'd0);
        check("reset addr", 32'(bus.rd_address), 32'd0);
        rst_n = 1'b1;
        err_tx = 0; err_busy = 0; err_done = 0; err_addr = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.tx !== 1'b1)           err_tx++;
            if (bus.busy !== 1'b0)         err_busy++;
            if (bus.done !== 1'b0)         err_done++;
            if (bus.rd_address !== 2'd0)   err_addr++;
        end
        check("idle tx errors",   32'(err_tx),   32'd0);
        check("idle busy errors", 32'(err_busy), 32'd0);
        check("idle done errors", 32'(err_done), 32'd0);
        check("idle addr errors", 32'(err_addr), 32'd0);

        // Full dump of {00,FF,A5,3C} with explicit look at the 0xA5 frame.
        add_ev(0, EV_START, 0, 0);
        record(180);
        check_dump("full", base_w, 180);
        check("frame2 ADDR rd_address", 32'(tr_addr[1 + 2 * WORD_CYC]), 32'd2);
        cnt = 0;
        for (int b = 0; b < DW; b++)
            for (int c = 0; c < CPB; c++)
                if (tr_tx[1 + 2 * WORD_CYC + 1 + CPB + b * CPB + c] === base_w[2][b]) cnt++;
        check("frame2 bit hold cycles", 32'(cnt), 32'(DW * CPB));
        cnt = 0;
        for (int c = 0; c < CPB; c++)
            if (tr_tx[1 + 2 * WORD_CYC + 1 + CPB + DW * CPB + c] === 1'b1) cnt++;
        check("frame2 stop bit cycles", 32'(cnt), 32'(CPB));

        // Falling-edge writes while frame 1 is in flight.
        load_regs(base_w);
        add_ev(0,  EV_START, 0, 0);
        add_ev(50, EV_WRITE, 3, 'h77);
        add_ev(60, EV_WRITE, 1, 'h12);
        record(180);
        check_dump("write", wr_w, 180);

        // Extra start pulses during frame 2 and on the done cycle are ignored.
        load_regs(base_w);
        add_ev(0,            EV_START, 0, 0);
        add_ev(90,           EV_START, 0, 0);
        add_ev(100,          EV_START, 0, 0);
        add_ev(BUSY_CYC + 1, EV_START, 0, 0);
        record(200);
        check_dump("restart", base_w, 200);

        // Reset during a zero data bit of frame 1, then a clean dump.
        load_regs(rst_w);
        add_ev(0,  EV_START,   0, 0);
        add_ev(48, EV_RST_ON,  0, 0);
        add_ev(52, EV_RST_OFF, 0, 0);
        record(80);
        check("pre-reset tx low", 32'(tr_tx[48]), 32'd0);
        cnt = 0;
        for (int k = 0; k < 80; k++) if (tr_done[k] === 1'b1) cnt++;
        check("reset run done pulses", 32'(cnt), 32'd0);
        cnt = 0;
        for (int k = 49; k < 80; k++) if (tr_tx[k] !== 1'b1 || tr_busy[k] !== 1'b0) cnt++;
        check("post-reset idle errors", 32'(cnt), 32'd0);
        add_ev(0, EV_START, 0, 0);
        record(180);
        check_dump("after reset", rst_w, 180);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
